// File: rtl/ser_packet_pkg.sv
// Shared types and defaults for the serial packet demultiplexer.
package ser_packet_pkg;

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        LEN,
        DATA,
        PARITY,
        DONE
    } state_t;

    localparam int         DEF_NUM_CH    = 4;
    localparam int         DEF_LEN_W     = 4;
    localparam int         DEF_START_LEN = 4;
    localparam logic [3:0] DEF_START_PAT = 4'b1101;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ser_packet_demux_start_det.sv
// Start-pattern detector: shift history plus a saturating fill counter so that
// a match is only reported once START_LEN real bits have been seen.
module ser_start_det
    import ser_packet_pkg::*;
#(
    parameter int                   START_LEN = DEF_START_LEN,
    parameter logic [START_LEN-1:0] START_PAT = START_LEN'(DEF_START_PAT)
) (
    input  logic clk,
    input  logic clear_i,
    input  logic en_i,
    input  logic bit_i,
    output logic match_o
);
    localparam int FILL_W = $clog2(START_LEN + 1);

    logic [START_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]    fill_q, fill_d;

    always_comb begin
        hist_d = (hist_q << 1) | START_LEN'(bit_i);
        fill_d = (fill_q == FILL_W'(START_LEN)) ? fill_q : fill_q + 1'b1;
    end

    // Match looks at the history including the bit arriving this cycle.
    assign match_o = en_i && (fill_d == FILL_W'(START_LEN)) && (hist_d == START_PAT);

    always_ff @(posedge clk) begin
        if (clear_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (en_i) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/ser_packet_demux.sv
// Serial packet receiver: start hunt, address, length, payload steering.
// Optional trailing even-parity bit when SER_PACKET_PARITY_EN is defined.
module ser_packet_demux
    import ser_packet_pkg::*;
#(
    parameter int                   NUM_CH    = DEF_NUM_CH,
    parameter int                   ADDR_W    = $clog2(NUM_CH),
    parameter int                   LEN_W     = DEF_LEN_W,
    parameter int                   START_LEN = DEF_START_LEN,
    parameter logic [START_LEN-1:0] START_PAT = START_LEN'(DEF_START_PAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serIn,
    output logic [NUM_CH-1:0] serOut,
    output logic [NUM_CH-1:0] serOutValid,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_W = max_w(ADDR_W, LEN_W);
`ifdef SER_PACKET_PARITY_EN
    localparam state_t POST_DATA = PARITY;
`else
    localparam state_t POST_DATA = DONE;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               match;
    logic               addr_ok;
    logic               pkt_bad;

    ser_start_det #(
        .START_LEN(START_LEN),
        .START_PAT(START_PAT)
    ) u_start_det (
        .clk     (clk),
        .clear_i (rst || (state_q == DONE)),
        .en_i    (state_q == HUNT),
        .bit_i   (serIn),
        .match_o (match)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            HUNT: begin
                if (match) begin
                    state_d = ADDR;
                    cnt_d   = CNT_W'(ADDR_W - 1);
                end
            end
            ADDR: begin
                addr_d = (addr_q << 1) | ADDR_W'(serIn);
                if (cnt_q == '0) begin
                    state_d = LEN;
                    cnt_d   = CNT_W'(LEN_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LEN: begin
                len_d = (len_q << 1) | LEN_W'(serIn);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (len_d == '0) begin
                    state_d = POST_DATA;
                end else begin
                    state_d = DATA;
                    cnt_d   = CNT_W'(len_d - 1'b1);
                end
            end
            DATA: begin
                if (cnt_q == '0) state_d = POST_DATA;
                else             cnt_d   = cnt_q - 1'b1;
            end
            PARITY:  state_d = DONE;
            DONE:    state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    // An out-of-range address marks the packet bad whatever its length.
    assign addr_ok = (32'(addr_q) < NUM_CH);

`ifdef SER_PACKET_PARITY_EN
    logic par_q, par_d, par_bad_q, par_bad_d;

    always_comb begin
        par_d     = par_q;
        par_bad_d = par_bad_q;
        case (state_q)
            HUNT:             begin par_d = 1'b0; par_bad_d = 1'b0; end
            ADDR, LEN, DATA:  par_d = par_q ^ serIn;
            PARITY:           par_bad_d = par_q ^ serIn;
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q     <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            par_bad_q <= par_bad_d;
        end
    end

    assign pkt_bad = !addr_ok || par_bad_q;
`else
    assign pkt_bad = !addr_ok;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign serOutValid[gi] = (state_q == DATA) && (addr_q == ADDR_W'(gi));
        assign serOut[gi]      = serOutValid[gi] && serIn;
    end

    assign busy = (state_q != HUNT);
    assign done = (state_q == DONE);
    assign err  = done && pkt_bad;

endmodule

// File: tb/tb_ser_packet_demux.sv
// Randomised bench: builds a bit stream, derives per-cycle expectations by
// parsing the stream with array scans, then drives the DUT and compares.
module tb_ser_packet_demux;
    localparam int         NUM_CH    = 3;
    localparam int         ADDR_W    = 2;
    localparam int         LEN_W     = 4;
    localparam int         START_LEN = 4;
    localparam logic [3:0] START_PAT = 4'b1101;
    localparam int         MAXN      = 4000;
`ifdef SER_PACKET_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              serIn;
    logic [NUM_CH-1:0] serOut, serOutValid;
    logic              busy, done, err;

    always #5 clk = ~clk;

    ser_packet_demux #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .START_LEN(START_LEN), .START_PAT(START_PAT)
    ) dut (
        .clk(clk), .rst(rst), .serIn(serIn),
        .serOut(serOut), .serOutValid(serOutValid),
        .busy(busy), .done(done), .err(err)
    );

    logic              stim_bit [MAXN];
    logic              stim_rst [MAXN];
    int                n;
    logic [NUM_CH-1:0] exp_valid [MAXN];
    logic [NUM_CH-1:0] exp_out   [MAXN];
    logic              exp_busy  [MAXN];
    logic              exp_done  [MAXN];
    logic              exp_err   [MAXN];
    logic              err_care  [MAXN];
    int                exp_addr  [MAXN];
    int                exp_len   [MAXN];
    int                chk_cnt, pass_cnt, cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    function automatic void push(input logic b, input logic r);
        if (n < MAXN) begin
            stim_bit[n] = b;
            stim_rst[n] = r;
            n++;
        end
    endfunction

    function automatic logic push_field(input int val, input int w);
        logic p = 1'b0;
        for (int i = w - 1; i >= 0; i--) begin
            push(val[i], 1'b0);
            p ^= val[i];
        end
        return p;
    endfunction

    function automatic void push_packet(input int a, input int l, input int payload, input logic flip);
        logic p;
        void'(push_field(int'(START_PAT), START_LEN));
        p = push_field(a, ADDR_W);
        p ^= push_field(l, LEN_W);
        p ^= push_field(payload, l);
        if (PAR_EN != 0) push(p ^ flip, 1'b0);
    endfunction

    function automatic logic get(input int i);
        return (i < n) ? stim_bit[i] : 1'b0;
    endfunction

    function automatic int field(input int st, input int w);
        int v = 0;
        for (int i = 0; i < w; i++) v = (v << 1) | int'(get(st + i));
        return v;
    endfunction

    // Parse one reset-free span [s,e) of the stream into packets.
    function automatic void parse_segment(input int s, input int e);
        int pos = s;
        while (pos < e) begin
            int m = -1;
            int a, l, p0, d;
            logic bad, par;
            for (int i = pos + START_LEN - 1; i < e; i++)
                if (field(i - START_LEN + 1, START_LEN) == int'(START_PAT)) begin
                    m = i;
                    break;
                end
            if (m < 0) return;
            a  = field(m + 1, ADDR_W);
            l  = field(m + 1 + ADDR_W, LEN_W);
            p0 = m + 1 + ADDR_W + LEN_W;
            d  = p0 + l + PAR_EN;
            for (int c = m + 1; c <= d && c < e; c++) exp_busy[c] = 1'b1;
            for (int c = p0; c < p0 + l && c < e; c++)
                if (a < NUM_CH) begin
                    exp_valid[c] = NUM_CH'(1) << a;
                    exp_out[c]   = NUM_CH'(get(c)) << a;
                end
            bad = (a >= NUM_CH);
            if (PAR_EN != 0) begin
                par = 1'b0;
                for (int c = m + 1; c <= p0 + l; c++) par ^= get(c);
                bad = bad | par;
            end
            if (d < e) begin
                exp_done[d] = 1'b1;
                exp_err[d]  = bad;
                err_care[d] = !((a >= NUM_CH) && (l == 0));
                exp_addr[d] = a;
                exp_len[d]  = l;
            end
            pos = d + 1;
        end
    endfunction

    function automatic void build_expect();
        int s = 0;
        for (int k = 0; k < n; k++) begin
            exp_valid[k] = '0; exp_out[k] = '0;
            exp_busy[k] = 1'b0; exp_done[k] = 1'b0; exp_err[k] = 1'b0;
            err_care[k] = 1'b1; exp_addr[k] = 0; exp_len[k] = 0;
        end
        while (s < n) begin
            int e = s;
            while (e < n && !stim_rst[e]) e++;
            parse_segment(s, e);
            s = e + 1;
        end
    endfunction

    initial begin
        rst = 1'b1; serIn = 1'b0; n = 0; chk_cnt = 0; pass_cnt = 0; cyc = 0;
        push(1'b0, 1'b1); push(1'b0, 1'b1);
        push_packet(1, 3, 5, 1'b0);                     // ch1 gets 1,0,1
        push_packet(2, 0, 0, 1'b0);                     // zero length
        push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0);
        push_packet(3, 1, 1, 1'b0);                     // overlap prefix
        push_packet(3, 2, 2, 1'b0);                     // out-of-range channel
        push_packet(1, 2, 3, 1'b0);
        push_packet(1, 2, 3, 1'b1);                     // corrupted parity when enabled
        void'(push_field(int'(START_PAT), START_LEN));  // reset mid-payload
        void'(push_field(0, ADDR_W));
        void'(push_field(7, LEN_W));
        void'(push_field(5, 3));
        push(1'b1, 1'b1);
        push_packet(2, 3, 6, 1'b0);
        for (int t = 0; t < 40; t++) begin
            int a, l, ps;
            for (int j = $urandom_range(0, 5); j > 0; j--) push(1'($urandom), 1'b0);
            a = $urandom_range(0, 3);
            l = $urandom_range(0, 15);
            if (a >= NUM_CH && l == 0) l = 1;
            ps = n;
            push_packet(a, l, int'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 7) == 0) stim_rst[$urandom_range(ps, n - 1)] = 1'b1;
        end
        for (int j = 0; j < 8; j++) push(1'b0, 1'b0);
        build_expect();

        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rst   = stim_rst[k];
            serIn = stim_bit[k];
            @(negedge clk);
            cyc = k;
            if (!stim_rst[k]) begin
                check_eq("valid", 32'(serOutValid), 32'(exp_valid[k]));
                check_eq("serout", 32'(serOut), 32'(exp_out[k]));
                check_eq("busy", 32'(busy), 32'(exp_busy[k]));
                check_eq("done", 32'(done), 32'(exp_done[k]));
                if (err_care[k]) check_eq("err", 32'(err), 32'(exp_err[k]));
                if (exp_done[k])
                    $display("pkt cyc=%0d addr=%0d len=%0d err_exp=%0b err=%0b",
                             k, exp_addr[k], exp_len[k], exp_err[k], err);
            end
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
